// File: rtl/mwc_pkg.sv
// Shared types and default sizes for the memory-write checker.
package mwc_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_NEXP    = 8;
  localparam int DEF_TIMEOUT = 1024;

  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

  typedef enum logic [1:0] {NONE, ADDR, DATA, TIMEOUT} fail_code_t;

endpackage

// File: rtl/mwc_exp_table.sv
// Expected (address, data) table: synchronous write, asynchronous read.
module mwc_exp_table #(
  parameter int WIDTH = mwc_pkg::DEF_WIDTH,
  parameter int NEXP  = mwc_pkg::DEF_NEXP,
  localparam int IW   = $clog2(NEXP)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [IW-1:0]    wr_idx,
  input  logic [WIDTH-1:0] wr_adr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [IW-1:0]    rd_idx,
  output logic [WIDTH-1:0] rd_adr,
  output logic [WIDTH-1:0] rd_data
);

  logic [NEXP-1:0][WIDTH-1:0] adr_mem;
  logic [NEXP-1:0][WIDTH-1:0] data_mem;

  // Entry storage; the whole table is wiped by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      adr_mem  <= '0;
      data_mem <= '0;
    end else if (wr_en && (int'(wr_idx) < NEXP)) begin
      adr_mem[wr_idx]  <= wr_adr;
      data_mem[wr_idx] <= wr_data;
    end
  end

  // Out-of-range indices (non power-of-two depth) read as zero.
  always_comb begin
    rd_adr  = '0;
    rd_data = '0;
    if (int'(rd_idx) < NEXP) begin
      rd_adr  = adr_mem[rd_idx];
      rd_data = data_mem[rd_idx];
    end
  end

endmodule

// File: rtl/mem_write_checker.sv
// Checks processor data-memory writes against an ordered expected table.
// The entry under test is always table[match_count]; the run ends in PASS
// once exp_count entries have matched, or in FAIL on the first bad write
// or when the cycle budget runs out.
module mem_write_checker #(
  parameter int WIDTH   = mwc_pkg::DEF_WIDTH,
  parameter int NEXP    = mwc_pkg::DEF_NEXP,
  parameter int TIMEOUT = mwc_pkg::DEF_TIMEOUT,
  localparam int IW     = $clog2(NEXP),
  localparam int CW     = $clog2(NEXP + 1),
  localparam int TW     = $clog2(TIMEOUT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] dataadr,
  input  logic [WIDTH-1:0] writedata,
  input  logic             load_en,
  input  logic [IW-1:0]    load_idx,
  input  logic [WIDTH-1:0] load_adr,
  input  logic [WIDTH-1:0] load_data,
  input  logic [CW-1:0]    exp_count,
  input  logic             ign_en,
  input  logic [WIDTH-1:0] ign_adr,
  input  logic [WIDTH-1:0] ign_mask,
  input  logic             start,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       fail_code,
  output logic [IW-1:0]    fail_idx,
  output logic [WIDTH-1:0] fail_adr,
  output logic [WIDTH-1:0] fail_data,
  output logic [CW-1:0]    match_count,
  output logic [15:0]      ignored_count,
  output logic [TW-1:0]    cycle_count
);
  import mwc_pkg::*;

  localparam logic [TW-1:0] CYC_LAST = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] NEXP_C   = CW'(NEXP);

  state_t           state;
  fail_code_t       code_q;
  fail_code_t       code_n;
  logic [CW-1:0]    exp_lat;
  logic             ign_en_q;
  logic [WIDTH-1:0] ign_adr_q;
  logic [WIDTH-1:0] ign_mask_q;
  logic [WIDTH-1:0] exp_adr;
  logic [WIDTH-1:0] exp_data;
  logic             adr_hit, data_hit, ign_hit, last;
  logic             do_match, do_ign, to_pass, to_fail;

  mwc_exp_table #(.WIDTH(WIDTH), .NEXP(NEXP)) u_table (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (load_en && (state == IDLE)),
    .wr_idx  (load_idx),
    .wr_adr  (load_adr),
    .wr_data (load_data),
    .rd_idx  (match_count[IW-1:0]),
    .rd_adr  (exp_adr),
    .rd_data (exp_data)
  );

  assign adr_hit   = (dataadr == exp_adr);
  assign data_hit  = (writedata == exp_data);
  assign ign_hit   = ign_en_q && ((dataadr & ign_mask_q) == (ign_adr_q & ign_mask_q));
  assign last      = (match_count == exp_lat - CW'(1));
  assign fail_code = code_q;

  // Per-edge verdict while running. A write on the final budget cycle is
  // judged first; only an undecided final cycle becomes a timeout.
  always_comb begin
    do_match = 1'b0;
    do_ign   = 1'b0;
    to_pass  = 1'b0;
    to_fail  = 1'b0;
    code_n   = NONE;
    if (memwrite) begin
      if (adr_hit && data_hit) begin
        do_match = 1'b1;
        to_pass  = last;
      end else if (adr_hit) begin
        to_fail = 1'b1;
        code_n  = DATA;
      end else if (ign_hit) begin
        do_ign = 1'b1;
      end else begin
        to_fail = 1'b1;
        code_n  = ADDR;
      end
    end
    if (!to_pass && !to_fail && (cycle_count == CYC_LAST)) begin
      to_fail = 1'b1;
      code_n  = mwc_pkg::TIMEOUT;
    end
  end

  // FSM, counters and failure capture. The result flags follow the state
  // one cycle later and are dropped on the edge that restarts a run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      code_q        <= NONE;
      exp_lat       <= '0;
      ign_en_q      <= 1'b0;
      ign_adr_q     <= '0;
      ign_mask_q    <= '0;
      done          <= 1'b0;
      pass          <= 1'b0;
      fail          <= 1'b0;
      fail_idx      <= '0;
      fail_adr      <= '0;
      fail_data     <= '0;
      match_count   <= '0;
      ignored_count <= '0;
      cycle_count   <= '0;
    end else begin
      pass <= (state == PASS) && !start;
      fail <= (state == FAIL) && !start;
      done <= ((state == PASS) || (state == FAIL)) && !start;
      case (state)
        RUN: begin
          if (exp_lat == '0) begin
            state <= PASS;
          end else begin
            if (cycle_count != CYC_LAST) cycle_count <= cycle_count + 1'b1;
            if (do_match) match_count <= match_count + 1'b1;
            if (do_ign && (ignored_count != 16'hFFFF)) ignored_count <= ignored_count + 1'b1;
            if (to_pass) begin
              state <= PASS;
            end else if (to_fail) begin
              state    <= FAIL;
              code_q   <= code_n;
              // A non-final match on the last cycle leaves the next entry pending.
              fail_idx <= do_match ? match_count[IW-1:0] + 1'b1 : match_count[IW-1:0];
              if (code_n != mwc_pkg::TIMEOUT) begin
                fail_adr  <= dataadr;
                fail_data <= writedata;
              end
            end
          end
        end
        default: begin
          if (start) begin
            state         <= RUN;
            exp_lat       <= (exp_count > NEXP_C) ? NEXP_C : exp_count;
            ign_en_q      <= ign_en;
            ign_adr_q     <= ign_adr;
            ign_mask_q    <= ign_mask;
            code_q        <= NONE;
            fail_idx      <= '0;
            fail_adr      <= '0;
            fail_data     <= '0;
            match_count   <= '0;
            ignored_count <= '0;
            cycle_count   <= '0;
          end
        end
      endcase
    end
  end

endmodule
